// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
package mem_bus_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // Round-robin pick: on a tie the requester that did not own the bus last wins.
  function automatic owner_e pick_owner(input logic m0_act, input logic m1_act,
                                        input owner_e last_owner);
    owner_e pick;
    if (m0_act && m1_act) begin
      pick = (last_owner == OWNER_M0) ? OWNER_M1 : OWNER_M0;
    end else if (m1_act) begin
      pick = OWNER_M1;
    end else begin
      pick = OWNER_M0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Saturating wait counter that flags expiry after TIMEOUT_CYCLES enabled cycles.
// TIMEOUT_CYCLES of 0 never expires.
module bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, then a saturating increment while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {CW{1'b0}};
    end else if (en_i && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one strobe/done memory port between m0 (CPU) and m1 (DMA).
// Grant is held for a whole transaction; a watchdog forces an error completion.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_wen,
  input  logic        m0_ren,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_wen,
  input  logic        m1_ren,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  output logic        s_wen,
  output logic        s_ren,
  input  logic [31:0] s_rdata,
  input  logic        s_done,
  output logic        timeout_err,
  output logic        grant_owner
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  owner_e last_q, last_d;

  logic        grant_s, own_m1_s, owner_act_s;
  logic        done_s, abort_s, wd_en_s, timeout_s, complete_s;
  logic [31:0] own_addr_s, own_wdata_s;
  logic [3:0]  own_wmask_s;
  logic        own_wen_s, own_ren_s;

  // Gating by rst drops the slave strobes in the very cycle reset is asserted.
  assign grant_s     = rst && (state_q == ST_GRANT);
  assign own_m1_s    = (owner_q == OWNER_M1);
  assign own_addr_s  = own_m1_s ? m1_addr  : m0_addr;
  assign own_wdata_s = own_m1_s ? m1_wdata : m0_wdata;
  assign own_wmask_s = own_m1_s ? m1_wmask : m0_wmask;
  assign own_wen_s   = own_m1_s ? m1_wen   : m0_wen;
  assign own_ren_s   = own_m1_s ? m1_ren   : m0_ren;
  assign owner_act_s = own_wen_s | own_ren_s;

  // s_done has priority over both abort and timeout.
  assign done_s     = grant_s & s_done;
  assign abort_s    = grant_s & ~s_done & ~owner_act_s;
  assign wd_en_s    = grant_s & ~s_done & owner_act_s;
  assign complete_s = done_s | timeout_s;

  bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clear_i  (~grant_s),
    .en_i     (wd_en_s),
    .expire_o (timeout_s)
  );

  // Slave-side mux: owner's request while granted, strobes killed on timeout.
  always_comb begin
    s_addr  = 32'h0000_0000;
    s_wdata = 32'h0000_0000;
    s_wmask = 4'b0000;
    s_wen   = 1'b0;
    s_ren   = 1'b0;
    if (grant_s) begin
      s_addr  = own_addr_s;
      s_wdata = own_wdata_s;
      s_wmask = own_wmask_s;
      s_wen   = own_wen_s & ~timeout_s;
      s_ren   = own_ren_s & ~timeout_s;
    end else begin
      s_wen   = 1'b0;
      s_ren   = 1'b0;
    end
  end

  assign m0_done     = complete_s & ~own_m1_s;
  assign m1_done     = complete_s &  own_m1_s;
  assign m0_rdata    = (timeout_s && !own_m1_s) ? ERR_RDATA : s_rdata;
  assign m1_rdata    = (timeout_s &&  own_m1_s) ? ERR_RDATA : s_rdata;
  assign timeout_err = timeout_s;
  assign grant_owner = owner_q;

  // Arbitration and transaction-end next-state logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_ren | m0_wen | m1_ren | m1_wen) begin
          state_d = ST_GRANT;
          owner_d = pick_owner(m0_ren | m0_wen, m1_ren | m1_wen, last_q);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (done_s | abort_s | timeout_s) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register; last owner resets to m1 so m0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_M0;
      last_q  <= OWNER_M1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter, built with a 4-cycle watchdog.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_wen, m0_ren, m1_wen, m1_ren;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_done, m1_done;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wmask;
  logic        s_wen, s_ren, s_done;
  logic        timeout_err, grant_owner;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES (4),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_wmask    (m0_wmask),
    .m0_wen      (m0_wen),
    .m0_ren      (m0_ren),
    .m0_rdata    (m0_rdata),
    .m0_done     (m0_done),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_wmask    (m1_wmask),
    .m1_wen      (m1_wen),
    .m1_ren      (m1_ren),
    .m1_rdata    (m1_rdata),
    .m1_done     (m1_done),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wmask     (s_wmask),
    .s_wen       (s_wen),
    .s_ren       (s_ren),
    .s_rdata     (s_rdata),
    .s_done      (s_done),
    .timeout_err (timeout_err),
    .grant_owner (grant_owner)
  );

  // Each cycle starts 1 ns after the rising edge; inputs change there, checks follow 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; s_rdata = 32'hA5A5_A5A5; s_done = 1'b1; m0_ren = 1'b1;
    tick(); tick(); #1;
    total_cnt++; if (s_ren !== 1'b0) $display("FAIL rst_s_ren got %b exp 0", s_ren); else pass_cnt++;
    total_cnt++; if (s_wen !== 1'b0) $display("FAIL rst_s_wen got %b exp 0", s_wen); else pass_cnt++;
    total_cnt++; if (s_addr !== 32'h0) $display("FAIL rst_s_addr got %h exp 0", s_addr); else pass_cnt++;
    total_cnt++; if ({m0_done, m1_done} !== 2'b00) $display("FAIL rst_done got %b exp 00", {m0_done, m1_done}); else pass_cnt++;
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout got %b exp 0", timeout_err); else pass_cnt++;
    total_cnt++; if (grant_owner !== 1'b0) $display("FAIL rst_owner got %b exp 0", grant_owner); else pass_cnt++;
    total_cnt++; if (m0_rdata !== 32'hA5A5_A5A5) $display("FAIL rst_m0_rdata got %h exp a5a5a5a5", m0_rdata); else pass_cnt++;
    total_cnt++; if (m1_rdata !== 32'hA5A5_A5A5) $display("FAIL rst_m1_rdata got %h exp a5a5a5a5", m1_rdata); else pass_cnt++;
    m0_ren = 1'b0; s_done = 1'b0;
    tick(); rst = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    m0_ren = 1'b1; m0_addr = 32'h0000_0100; #1;
    total_cnt++; if (s_ren !== 1'b0) $display("FAIL rd_c0_s_ren got %b exp 0", s_ren); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (s_ren !== 1'b1) $display("FAIL rd_c1_s_ren got %b exp 1", s_ren); else pass_cnt++;
    total_cnt++; if (s_addr !== 32'h0000_0100) $display("FAIL rd_c1_s_addr got %h exp 00000100", s_addr); else pass_cnt++;
    total_cnt++; if (m0_done !== 1'b0) $display("FAIL rd_c1_m0_done got %b exp 0", m0_done); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (s_ren !== 1'b1) $display("FAIL rd_c2_s_ren got %b exp 1", s_ren); else pass_cnt++;
    tick(); s_done = 1'b1; s_rdata = 32'h1234_5678; #1;
    total_cnt++; if (m0_done !== 1'b1) $display("FAIL rd_c3_m0_done got %b exp 1", m0_done); else pass_cnt++;
    total_cnt++; if (m0_rdata !== 32'h1234_5678) $display("FAIL rd_c3_m0_rdata got %h exp 12345678", m0_rdata); else pass_cnt++;
    total_cnt++; if (m1_done !== 1'b0) $display("FAIL rd_c3_m1_done got %b exp 0", m1_done); else pass_cnt++;
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL rd_c3_timeout got %b exp 0", timeout_err); else pass_cnt++;
    tick(); s_done = 1'b0; m0_ren = 1'b0; #1;
    total_cnt++; if ({s_ren, m0_done} !== 2'b00) $display("FAIL rd_c4_idle got %b exp 00", {s_ren, m0_done}); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    rst = 1'b0; tick(); rst = 1'b1;
    m0_ren = 1'b1; m0_addr = 32'h0000_0200;
    m1_wen = 1'b1; m1_addr = 32'h0000_0300; m1_wdata = 32'hCAFE_F00D; m1_wmask = 4'b0011; #1;
    total_cnt++; if ({s_ren, s_wen} !== 2'b00) $display("FAIL rr_c0_strobes got %b exp 00", {s_ren, s_wen}); else pass_cnt++;
    tick(); s_done = 1'b1; s_rdata = 32'h1111_1111; #1;
    total_cnt++; if (grant_owner !== 1'b0) $display("FAIL rr_g1_owner got %b exp 0", grant_owner); else pass_cnt++;
    total_cnt++; if ({s_ren, s_wen} !== 2'b10) $display("FAIL rr_g1_strobes got %b exp 10", {s_ren, s_wen}); else pass_cnt++;
    total_cnt++; if ({m0_done, m1_done} !== 2'b10) $display("FAIL rr_g1_done got %b exp 10", {m0_done, m1_done}); else pass_cnt++;
    tick(); s_done = 1'b0; #1;
    total_cnt++; if ({s_ren, s_wen} !== 2'b00) $display("FAIL rr_idle1_strobes got %b exp 00", {s_ren, s_wen}); else pass_cnt++;
    tick(); s_done = 1'b1; #1;
    total_cnt++; if (grant_owner !== 1'b1) $display("FAIL rr_g2_owner got %b exp 1", grant_owner); else pass_cnt++;
    total_cnt++; if ({s_ren, s_wen} !== 2'b01) $display("FAIL rr_g2_strobes got %b exp 01", {s_ren, s_wen}); else pass_cnt++;
    total_cnt++; if (s_wmask !== 4'b0011) $display("FAIL rr_g2_wmask got %b exp 0011", s_wmask); else pass_cnt++;
    total_cnt++; if (s_addr !== 32'h0000_0300) $display("FAIL rr_g2_addr got %h exp 00000300", s_addr); else pass_cnt++;
    total_cnt++; if (s_wdata !== 32'hCAFE_F00D) $display("FAIL rr_g2_wdata got %h exp cafef00d", s_wdata); else pass_cnt++;
    total_cnt++; if ({m0_done, m1_done} !== 2'b01) $display("FAIL rr_g2_done got %b exp 01", {m0_done, m1_done}); else pass_cnt++;
    tick(); s_done = 1'b0; #1;
    total_cnt++; if ({s_ren, s_wen} !== 2'b00) $display("FAIL rr_idle2_strobes got %b exp 00", {s_ren, s_wen}); else pass_cnt++;
    tick(); s_done = 1'b1; #1;
    total_cnt++; if (grant_owner !== 1'b0) $display("FAIL rr_g3_owner got %b exp 0", grant_owner); else pass_cnt++;
    total_cnt++; if ({m0_done, m1_done} !== 2'b10) $display("FAIL rr_g3_done got %b exp 10", {m0_done, m1_done}); else pass_cnt++;
    tick(); s_done = 1'b0; m0_ren = 1'b0; m1_wen = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    m1_ren = 1'b1; m1_addr = 32'h0000_0400; s_rdata = 32'h5555_AAAA;
    tick(); #1;
    total_cnt++; if ({s_ren, m1_done, timeout_err} !== 3'b100) $display("FAIL to_g1 got %b exp 100", {s_ren, m1_done, timeout_err}); else pass_cnt++;
    tick(); tick(); #1;
    total_cnt++; if ({m1_done, timeout_err} !== 2'b00) $display("FAIL to_g3_early got %b exp 00", {m1_done, timeout_err}); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (m1_done !== 1'b1) $display("FAIL to_g4_m1_done got %b exp 1", m1_done); else pass_cnt++;
    total_cnt++; if (m1_rdata !== 32'hDEAD_BEEF) $display("FAIL to_g4_m1_rdata got %h exp deadbeef", m1_rdata); else pass_cnt++;
    total_cnt++; if (timeout_err !== 1'b1) $display("FAIL to_g4_err got %b exp 1", timeout_err); else pass_cnt++;
    total_cnt++; if (s_ren !== 1'b0) $display("FAIL to_g4_s_ren got %b exp 0", s_ren); else pass_cnt++;
    total_cnt++; if (m0_done !== 1'b0) $display("FAIL to_g4_m0_done got %b exp 0", m0_done); else pass_cnt++;
    total_cnt++; if (m0_rdata !== 32'h5555_AAAA) $display("FAIL to_g4_m0_rdata got %h exp 5555aaaa", m0_rdata); else pass_cnt++;
    tick(); #1;
    total_cnt++; if ({s_ren, m1_done, timeout_err} !== 3'b000) $display("FAIL to_idle got %b exp 000", {s_ren, m1_done, timeout_err}); else pass_cnt++;
    m1_ren = 1'b0;
    tick();
  endtask

  task automatic test_done_at_timeout();
    m0_ren = 1'b1; m0_addr = 32'h0000_0500;
    tick(); tick(); tick();
    tick(); s_done = 1'b1; s_rdata = 32'h0BAD_F00D; #1;
    total_cnt++; if (m0_done !== 1'b1) $display("FAIL dt_m0_done got %b exp 1", m0_done); else pass_cnt++;
    total_cnt++; if (m0_rdata !== 32'h0BAD_F00D) $display("FAIL dt_m0_rdata got %h exp 0badf00d", m0_rdata); else pass_cnt++;
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL dt_err got %b exp 0", timeout_err); else pass_cnt++;
    total_cnt++; if (s_ren !== 1'b1) $display("FAIL dt_s_ren got %b exp 1", s_ren); else pass_cnt++;
    tick(); s_done = 1'b0; m0_ren = 1'b0; #1;
    total_cnt++; if ({s_ren, m0_done} !== 2'b00) $display("FAIL dt_idle got %b exp 00", {s_ren, m0_done}); else pass_cnt++;
  endtask

  task automatic test_abort();
    m1_wen = 1'b1; m1_addr = 32'h0000_0600; m0_ren = 1'b1; m0_addr = 32'h0000_0700;
    tick(); #1;
    total_cnt++; if (grant_owner !== 1'b1) $display("FAIL ab_g1_owner got %b exp 1", grant_owner); else pass_cnt++;
    total_cnt++; if ({s_ren, s_wen} !== 2'b01) $display("FAIL ab_g1_strobes got %b exp 01", {s_ren, s_wen}); else pass_cnt++;
    tick(); m1_wen = 1'b0; #1;
    total_cnt++; if ({s_ren, s_wen} !== 2'b00) $display("FAIL ab_g2_strobes got %b exp 00", {s_ren, s_wen}); else pass_cnt++;
    total_cnt++; if ({m0_done, m1_done} !== 2'b00) $display("FAIL ab_g2_done got %b exp 00", {m0_done, m1_done}); else pass_cnt++;
    tick(); s_done = 1'b1; #1;
    total_cnt++; if ({s_ren, m0_done, m1_done} !== 3'b000) $display("FAIL ab_idle_sdone got %b exp 000", {s_ren, m0_done, m1_done}); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (grant_owner !== 1'b0) $display("FAIL ab_m0_owner got %b exp 0", grant_owner); else pass_cnt++;
    total_cnt++; if (s_addr !== 32'h0000_0700) $display("FAIL ab_m0_addr got %h exp 00000700", s_addr); else pass_cnt++;
    total_cnt++; if (m0_done !== 1'b1) $display("FAIL ab_m0_done got %b exp 1", m0_done); else pass_cnt++;
    tick(); s_done = 1'b0; m0_ren = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    m0_ren = 1'b1; m0_addr = 32'h0000_0800;
    tick(); #1;
    total_cnt++; if (s_ren !== 1'b1) $display("FAIL rm_grant_s_ren got %b exp 1", s_ren); else pass_cnt++;
    rst = 1'b0; #1;
    total_cnt++; if (s_ren !== 1'b0) $display("FAIL rm_assert_s_ren got %b exp 0", s_ren); else pass_cnt++;
    tick(); m1_ren = 1'b1; m1_addr = 32'h0000_0900; #1;
    total_cnt++; if ({s_ren, m0_done, m1_done} !== 3'b000) $display("FAIL rm_in_reset got %b exp 000", {s_ren, m0_done, m1_done}); else pass_cnt++;
    rst = 1'b1;
    tick(); #1;
    total_cnt++; if (grant_owner !== 1'b0) $display("FAIL rm_tie_owner got %b exp 0", grant_owner); else pass_cnt++;
    total_cnt++; if (s_addr !== 32'h0000_0800) $display("FAIL rm_tie_addr got %h exp 00000800", s_addr); else pass_cnt++;
    m0_ren = 1'b0; m1_ren = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; s_done = 1'b0; s_rdata = 32'h0;
    m0_addr = 32'h0; m0_wdata = 32'h0; m0_wmask = 4'h0; m0_wen = 1'b0; m0_ren = 1'b0;
    m1_addr = 32'h0; m1_wdata = 32'h0; m1_wmask = 4'h0; m1_wen = 1'b0; m1_ren = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_done_at_timeout();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory bus port between two requesters: m0 (the CPU) and m1 (a DMA or debug loader).
- Uses the same strobe/done protocol as the CPU bus on every side. A requester holds ren or wen, address, data and mask steady until it sees done.
- Arbitrates round-robin with one registered owner and holds the grant for a whole transaction.
- A watchdog ends any transaction the memory never completes, so the CPU FSM cannot hang.

Parameters:
- TIMEOUT_CYCLES, 255, cycles in GRANT without s_done before a forced error completion; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned to the owner on a timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (logic held in reset while rst==0 at posedge clk)
- m0_addr, m1_addr  in  32  requester address
- m0_wdata, m1_wdata  in  32  requester write data
- m0_wmask, m1_wmask  in  4  requester byte write mask
- m0_wen, m1_wen  in  1  write request
- m0_ren, m1_ren  in  1  read request
- m0_rdata, m1_rdata  out  32  read data, s_rdata broadcast; ERR_RDATA to the owner in the timeout cycle
- m0_done, m1_done  out  1  completion pulse, only to the owner
- s_addr  out  32  memory address
- s_wdata  out  32  memory write data
- s_wmask  out  4  memory byte write mask
- s_wen  out  1  memory write strobe
- s_ren  out  1  memory read strobe
- s_rdata  in  32  memory read data
- s_done  in  1  memory read or write complete
- timeout_err  out  1  one-cycle pulse when the watchdog fires
- grant_owner  out  1  current or last owner, for debug

Behaviour:
- A requester is active when mX_ren | mX_wen is high.
- State IDLE:
  - s_ren/s_wen = 0 and all done = 0; s_addr/s_wdata/s_wmask = 0.
  - If any requester is active, latch owner and go to GRANT at the next posedge. Arbitration latency is 1 cycle.
  - If both are active, pick the one that is not last_owner.
  - After reset last_owner = 1, so m0 (CPU) wins the first tie.
- State GRANT:
  - s_* are driven combinationally from the owner's mX_* signals.
  - The non-owner's strobes are ignored; its done stays 0.
  - s_done=1: mOwner_done=1 in the same cycle (combinational pass-through); last_owner <= owner; next state IDLE.
  - Owner deasserts both ren and wen before s_done (abort): s_ren/s_wen drop immediately, no done is issued, next state IDLE, last_owner is updated.
  - Wait counter increments each GRANT cycle without s_done; cleared on entry to GRANT.
  - Counter reaching TIMEOUT_CYCLES−1 with s_done still low (timeout cycle):
    - mOwner_done=1 and mOwner_rdata=ERR_RDATA that cycle.
    - timeout_err=1 for 1 cycle.
    - s_ren/s_wen forced to 0 that cycle.
    - Next state IDLE.
  - s_done and timeout in the same cycle: s_done wins, normal completion, no error.
- Back-to-back: after a done, the arbiter spends one IDLE cycle before it can grant again, so a transaction costs at least 2 cycles plus memory latency. This is required so the CPU FSM drops its strobe first and a stale strobe is not re-granted.
- s_done while IDLE is ignored.
- ren and wen both high on the owner: both are forwarded unchanged.
- Reset:
  - Any state goes to IDLE; owner = 0; last_owner = 1; counter = 0.
  - All outputs are 0, except that mX_rdata shows s_rdata.
  - Reset mid-transaction drops the slave strobes the same cycle rst is sampled low. No done is issued.
- Counter width is clog2(TIMEOUT_CYCLES+1), with a minimum of 1. It saturates and does not wrap.

Decomposition:
- Package mem_bus_pkg:
  - state enum (IDLE, GRANT)
  - owner encoding (OWNER_M0=0, OWNER_M1=1)
  - default ERR_RDATA constant
- Sub-module bus_watchdog: counter with clear/enable/expire, parameterised by TIMEOUT_CYCLES. It is reusable on other bus masters.
- The arbiter FSM and the muxing stay in mem_bus_arbiter.

Test Plan:
- Single read, m0 only:
  - Stimulus: m0_ren=1, m0_addr=0x100; memory answers s_done after 2 GRANT cycles with s_rdata=0x12345678.
  - Response: s_ren high from cycle 1; m0_done=1 with m0_rdata=0x12345678 at cycle 3; IDLE at cycle 4; m1_done stays 0.
- Simultaneous requests after reset:
  - Stimulus: m0_ren and m1_wen asserted at cycle 0, both held.
  - Response: m0 is served first. m1 is granted in the cycle after IDLE, with s_wen=1 and s_wmask=m1_wmask=4'b0011. Grants then alternate m0, m1, m0.
- Timeout, TIMEOUT_CYCLES=4:
  - Stimulus: m1_ren held; s_done never asserted.
  - Response: m1_done=1 with m1_rdata=0xDEADBEEF and timeout_err=1 in the 4th GRANT cycle; s_ren low that cycle; IDLE next.
- Done and timeout coincide:
  - Stimulus: s_done asserted in the same cycle the counter expires.
  - Response: m0_rdata=s_rdata and timeout_err=0.
- Abort:
  - Stimulus: m1 drops m1_wen in the 2nd GRANT cycle.
  - Response: s_wen=0 that cycle, no m1_done, IDLE next. A pending m0 request is granted in the following cycle.
- Reset mid-transaction:
  - Stimulus: rst=0 during GRANT with m0 owning.
  - Response: s_ren=0 at that edge and all done=0. After rst=1, the first tie goes to m0.
